// File: rtl/barrel_engine.sv
// barrel_engine
//   Obstacle engine for the running scene. Owns four barrel slots that spawn
//   at the top-left, roll along four platforms and fall between them.
//   Ports:
//     clk        system clock
//     rst        synchronous active-high reset
//     tick       one-clk frame-update strobe
//     run        game running; 0 freezes motion, spawning and hit detection
//     mario_x/y  Mario reference point (box 60x80 around it)
//     x/y        current VGA pixel
//     barrel_on  registered: pixel lies inside an active barrel
//     barrel_id  registered: lowest slot index covering the pixel
//     hit        sticky collision flag
//     dodged     saturating count of barrels that left the screen
module barrel_engine #(
  parameter int SPAWN_PERIOD = 64,
  parameter int ROLL_SPEED   = 2,
  parameter int FALL_SPEED   = 4,
  parameter int X_MIN        = 40,
  parameter int X_MAX        = 600,
  parameter int PLAT_Y0      = 100,
  parameter int PLAT_GAP     = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       run,
  input  logic [9:0] mario_x,
  input  logic [8:0] mario_y,
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic       barrel_on,
  output logic [1:0] barrel_id,
  output logic       hit,
  output logic [7:0] dodged
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ROLL = 2'd1;
  localparam logic [1:0] S_FALL = 2'd2;

  localparam logic [15:0] CNT_TOP = 16'(SPAWN_PERIOD - 1);

  logic [1:0]  st_q   [4];
  logic [9:0]  bx_q   [4];
  logic [8:0]  by_q   [4];
  logic [1:0]  plat_q [4];
  logic [1:0]  st_d   [4];
  logic [9:0]  bx_d   [4];
  logic [8:0]  by_d   [4];
  logic [1:0]  plat_d [4];
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  dod_d;
  logic        on_d;
  logic [1:0]  id_d;
  logic        overlap;

  // Next-state for one frame update. Motion is computed first; the spawn
  // then looks only at slots that were IDLE before this update, so a slot
  // despawning now is not reused until the following update.
  always_comb begin
    int  bxi;
    int  byi;
    int  tgt;
    logic spawned;
    cnt_d   = cnt_q;
    dod_d   = dodged;
    spawned = 1'b0;
    bxi     = 0;
    byi     = 0;
    tgt     = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      st_d[i]   = st_q[i];
      bx_d[i]   = bx_q[i];
      by_d[i]   = by_q[i];
      plat_d[i] = plat_q[i];
      bxi = int'(bx_q[i]);
      byi = int'(by_q[i]);
      tgt = PLAT_Y0 + (int'(plat_q[i]) + 1) * PLAT_GAP;
      case (st_q[i])
        S_ROLL: begin
          if (!plat_q[i][0]) begin
            if (bxi + ROLL_SPEED >= X_MAX) begin
              bx_d[i] = 10'(X_MAX);
              st_d[i] = S_FALL;
            end else begin
              bx_d[i] = 10'(bxi + ROLL_SPEED);
            end
          end else begin
            if (bxi <= X_MIN + ROLL_SPEED) begin
              bx_d[i] = 10'(X_MIN);
              if (plat_q[i] == 2'd3) begin
                st_d[i] = S_IDLE;
                if (dod_d != 8'hFF) dod_d = dod_d + 8'd1;
              end else begin
                st_d[i] = S_FALL;
              end
            end else begin
              bx_d[i] = 10'(bxi - ROLL_SPEED);
            end
          end
        end
        S_FALL: begin
          if (byi + FALL_SPEED >= tgt) begin
            by_d[i]   = 9'(tgt);
            plat_d[i] = plat_q[i] + 2'd1;
            st_d[i]   = S_ROLL;
          end else begin
            by_d[i] = 9'(byi + FALL_SPEED);
          end
        end
        default: ;
      endcase
    end
    if (cnt_q == CNT_TOP) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!spawned && st_q[i] == S_IDLE) begin
          spawned   = 1'b1;
          st_d[i]   = S_ROLL;
          bx_d[i]   = 10'(X_MIN);
          by_d[i]   = 9'(PLAT_Y0);
          plat_d[i] = '0;
        end
      end
      if (spawned) cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Pixel coverage and Mario overlap, from registered slot positions.
  always_comb begin
    int dx;
    int dy;
    int mx;
    int my;
    on_d    = 1'b0;
    id_d    = '0;
    overlap = 1'b0;
    dx      = 0;
    dy      = 0;
    mx      = 0;
    my      = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (st_q[i] != S_IDLE) begin
        dx = int'(x) - int'(bx_q[i]);
        dy = int'(y) - int'(by_q[i]);
        if (!on_d && dx >= -8 && dx <= 7 && dy >= -8 && dy <= 7) begin
          on_d = 1'b1;
          id_d = 2'(i);
        end
        mx = int'(bx_q[i]) - int'(mario_x);
        my = int'(by_q[i]) - int'(mario_y);
        if (mx >= -37 && mx <= 37 && my >= -47 && my <= 47) overlap = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        st_q[i]   <= S_IDLE;
        bx_q[i]   <= '0;
        by_q[i]   <= '0;
        plat_q[i] <= '0;
      end
      cnt_q     <= '0;
      barrel_on <= 1'b0;
      barrel_id <= '0;
      hit       <= 1'b0;
      dodged    <= '0;
    end else begin
      barrel_on <= on_d;
      barrel_id <= id_d;
      if (run && overlap) hit <= 1'b1;
      if (tick && run) begin
        for (int unsigned i = 0; i < 4; i++) begin
          st_q[i]   <= st_d[i];
          bx_q[i]   <= bx_d[i];
          by_q[i]   <= by_d[i];
          plat_q[i] <= plat_d[i];
        end
        cnt_q  <= cnt_d;
        dodged <= dod_d;
      end
    end
  end

endmodule

// File: tb/tb_barrel_engine.sv
// tb_barrel_engine
//   Randomized bench for barrel_engine. A driver issues one stimulus per
//   clock and pushes the expected registered response into a queue; a
//   monitor pops and compares on the falling edge when the entry is due.
//   The reference model tracks each barrel only by its age (updates since
//   spawn) and derives position in closed form from the platform geometry.
module tb_barrel_engine;

  localparam int SP   = 64;
  localparam int RS   = 2;
  localparam int FS   = 4;
  localparam int XMIN = 40;
  localparam int XMAX = 600;
  localparam int PY0  = 100;
  localparam int PGAP = 100;
  localparam int R    = (XMAX - XMIN + RS - 1) / RS;  // updates per platform roll
  localparam int F    = (PGAP + FS - 1) / FS;         // updates per fall
  localparam int L    = 4 * R + 3 * F;                // lifetime in updates
  localparam int FAR_X = 1000;
  localparam int FAR_Y = 500;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       run = 1'b0;
  logic [9:0] mario_x = '0;
  logic [8:0] mario_y = '0;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic       barrel_on;
  logic [1:0] barrel_id;
  logic       hit;
  logic [7:0] dodged;

  barrel_engine #(
    .SPAWN_PERIOD(SP), .ROLL_SPEED(RS), .FALL_SPEED(FS),
    .X_MIN(XMIN), .X_MAX(XMAX), .PLAT_Y0(PY0), .PLAT_GAP(PGAP)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .run(run),
    .mario_x(mario_x), .mario_y(mario_y), .x(x), .y(y),
    .barrel_on(barrel_on), .barrel_id(barrel_id), .hit(hit), .dodged(dodged)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic       on;
    logic [1:0] id;
    logic       hit;
    logic [7:0] dod;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_err = 0;

  // Reference model state
  int m_age[4];
  int m_cnt;
  int m_dod;
  bit m_hit;
  int m_updates;

  function automatic void pos(input int a0, output int bx, output int by);
    int a;
    a  = a0;
    bx = 0;
    by = 0;
    for (int p = 0; p < 4; p++) begin
      int  yp;
      bit  right;
      yp    = PY0 + p * PGAP;
      right = (p % 2 == 0);
      if (a < R) begin
        bx = right ? XMIN + a * RS : XMAX - a * RS;
        by = yp;
        return;
      end
      a -= R;
      if (a < F) begin
        bx = right ? XMAX : XMIN;
        by = yp + a * FS;
        return;
      end
      a -= F;
    end
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 4; s++) m_age[s] = -1;
    m_cnt = 0;
    m_dod = 0;
    m_hit = 0;
  endtask

  task automatic model_update();
    bit idle_before[4];
    bit done;
    for (int s = 0; s < 4; s++) idle_before[s] = (m_age[s] < 0);
    for (int s = 0; s < 4; s++) begin
      if (m_age[s] >= 0) begin
        m_age[s]++;
        if (m_age[s] == L) begin
          m_age[s] = -1;
          if (m_dod < 255) m_dod++;
        end
      end
    end
    if (m_cnt == SP - 1) begin
      done = 0;
      for (int s = 0; s < 4; s++) begin
        if (!done && idle_before[s]) begin
          m_age[s] = 0;
          done = 1;
        end
      end
      if (done) m_cnt = 0;
    end else begin
      m_cnt++;
    end
    m_updates++;
  endtask

  task automatic step(input logic r, input logic rn, input logic tk,
                      input int px, input int py, input int mx, input int my);
    exp_t e;
    bit   ov;
    int   bx, by;
    @(posedge clk);
    #1;
    rst = r; run = rn; tick = tk;
    x = 10'(px); y = 9'(py);
    mario_x = 10'(mx); mario_y = 9'(my);
    e.due = cyc + 1;
    e.on = 1'b0;
    e.id = '0;
    ov = 0;
    if (r) begin
      model_reset();
    end else begin
      for (int s = 0; s < 4; s++) begin
        if (m_age[s] >= 0) begin
          pos(m_age[s], bx, by);
          if (!e.on && px >= bx - 8 && px <= bx + 7 && py >= by - 8 && py <= by + 7) begin
            e.on = 1'b1;
            e.id = 2'(s);
          end
          if (bx >= mx - 37 && bx <= mx + 37 && by >= my - 47 && by <= my + 47) ov = 1;
        end
      end
      if (rn && ov) m_hit = 1;
      if (rn && tk) model_update();
    end
    e.hit = m_hit;
    e.dod = 8'(m_dod);
    q.push_back(e);
  endtask

  task automatic pick_pixel(output int px, output int py);
    int s, bx, by;
    s = int'($urandom_range(0, 3));
    if ($urandom_range(0, 3) != 0 && m_age[s] >= 0) begin
      pos(m_age[s], bx, by);
      px = bx + int'($urandom_range(0, 20)) - 10;
      py = by + int'($urandom_range(0, 20)) - 10;
    end else begin
      px = int'($urandom_range(0, 639));
      py = int'($urandom_range(0, 479));
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      n_checks++;
      if (barrel_on !== e.on) begin
        n_err++;
        $display("FAIL barrel_on cyc=%0d got=%0b exp=%0b (x=%0d y=%0d)", cyc, barrel_on, e.on, x, y);
      end
      n_checks++;
      if (barrel_id !== e.id) begin
        n_err++;
        $display("FAIL barrel_id cyc=%0d got=%0d exp=%0d", cyc, barrel_id, e.id);
      end
      n_checks++;
      if (hit !== e.hit) begin
        n_err++;
        $display("FAIL hit cyc=%0d got=%0b exp=%0b", cyc, hit, e.hit);
      end
      n_checks++;
      if (dodged !== e.dod) begin
        n_err++;
        $display("FAIL dodged cyc=%0d got=%0d exp=%0d", cyc, dodged, e.dod);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int px, py, guard;
    model_reset();
    m_updates = 0;

    // Reset
    repeat (3) step(1, 0, 0, 0, 0, FAR_X, FAR_Y);

    // 63 updates: no barrel; interleave ignored ticks with run low
    for (int n = 0; n < 63; n++) begin
      pick_pixel(px, py);
      if ($urandom_range(0, 3) == 0) step(0, 0, 1, px, py, FAR_X, FAR_Y);
      step(0, 1, 1, XMIN, PY0, FAR_X, FAR_Y);
    end
    // 64th update spawns slot 0 at (40,100); probe box edges
    step(0, 1, 1, XMIN, PY0, FAR_X, FAR_Y);
    step(0, 1, 0, 40, 100, FAR_X, FAR_Y);
    step(0, 1, 0, 48, 100, FAR_X, FAR_Y);
    step(0, 1, 0, 47, 107, FAR_X, FAR_Y);
    step(0, 1, 0, 32, 92, FAR_X, FAR_Y);
    step(0, 1, 0, 31, 100, FAR_X, FAR_Y);
    step(0, 1, 0, 40, 108, FAR_X, FAR_Y);

    // Collision boundaries around the barrel at (40,100)
    repeat (2) step(0, 1, 0, 0, 0, 78, 100);
    step(0, 1, 0, 0, 0, 77, 148);
    repeat (2) step(0, 0, 0, 0, 0, 77, 100);
    step(0, 0, 1, 0, 0, 77, 100);
    step(0, 1, 0, 0, 0, 77, 100);
    repeat (3) step(0, 1, 0, 0, 0, FAR_X, FAR_Y);

    // Reset during a tick with a barrel active
    step(1, 1, 1, 40, 100, 77, 100);
    step(0, 1, 0, 40, 100, FAR_X, FAR_Y);

    // Long run through despawns, full slots and reuse
    m_updates = 0;
    guard = 0;
    while (m_updates < 1700 && guard < 6000) begin
      pick_pixel(px, py);
      if ($urandom_range(0, 15) == 0)
        step(0, 0, 1, px, py, FAR_X, FAR_Y);
      else
        step(0, 1, ($urandom_range(0, 3) != 0), px, py, FAR_X, FAR_Y);
      guard++;
    end
    n_checks++;
    if (m_updates < 1700) begin
      n_err++;
      $display("FAIL long_run_budget got=%0d exp=%0d updates", m_updates, 1700);
    end

    // Random Mario placement near active barrels
    for (int n = 0; n < 300; n++) begin
      int s, bx, by, mx, my;
      pick_pixel(px, py);
      s = int'($urandom_range(0, 3));
      mx = FAR_X;
      my = FAR_Y;
      if (m_age[s] >= 0) begin
        pos(m_age[s], bx, by);
        mx = bx + int'($urandom_range(0, 90)) - 45;
        my = by + int'($urandom_range(0, 110)) - 55;
        if (mx < 0) mx = 0;
      end
      step(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), px, py, mx, my);
    end

    // Drain the scoreboard
    step(0, 0, 0, 0, 0, FAR_X, FAR_Y);
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got=%0d exp=0 pending entries", q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
